// File: rtl/logic_unit_arbiter_if.sv
// Requester/consumer bundle for logic_unit_arbiter: two operation requesters
// and a single result consumer, all sharing one WIDTH-bit datapath.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_data, res_zero, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_data, res_zero, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a chunk-serial bitwise logic unit: one
// shared CHUNK-bit gate slice builds the WIDTH-bit result over NCHUNK cycles.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  logic_unit_arbiter_if.slave  bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             prio1;
  logic             res_valid_q;
  logic             res_id_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_zero_q;
  logic             busy_q;

  logic             grant0;
  logic             grant1;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] slice;

  // Same-cycle grant in IDLE; prio1 marks req0 as the most recent winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.req0_valid && (!bus.req1_valid || !prio1)) grant0 = 1'b1;
      else if (bus.req1_valid)                          grant1 = 1'b1;
    end
  end

  // Shared gate slice working on the chunk selected by k.
  always_comb begin
    slice = '0;
    a_k   = a_q[32'(k) * CHUNK +: CHUNK];
    b_k   = b_q[32'(k) * CHUNK +: CHUNK];
    case (op_q)
      2'b00:   slice = a_k & b_k;
      2'b01:   slice = a_k | b_k;
      2'b10:   slice = a_k ^ b_k;
      default: slice = '0;
    endcase
  end

  // res_valid is raised one cycle after entering DONE so res_zero is judged
  // on the complete result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      prio1       <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q        <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q        <= grant1 ? bus.req1_b  : bus.req0_b;
            op_q       <= grant1 ? bus.req1_op : bus.req0_op;
            res_id_q   <= grant1;
            prio1      <= grant0;
            k          <= '0;
            res_data_q <= '0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res_data_q[32'(k) * CHUNK +: CHUNK] <= slice;
          if (k == KW'(NCHUNK - 1)) state <= DONE;
          else                      k     <= k + KW'(1);
        end
        DONE: begin
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_zero_q  <= (res_data_q == '0);
          end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            res_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_zero   = res_zero_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized bench for logic_unit_arbiter against a word-level
// reference model (whole-word logic ops, grant history queue).
module tb_logic_unit_arbiter;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   grant_hist[$];
  logic [63:0] last_data;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus();

  logic_unit_arbiter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return 64'd0;
    endcase
  endfunction

  // Both valid: the one not granted last (req0 if nothing granted since reset).
  function automatic int ref_grant(input bit v0, input bit v1);
    if (v0 && v1) return (grant_hist.size() == 0) ? 0 : 1 - grant_hist[$];
    return v0 ? 0 : 1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_op(input bit v0, input bit v1,
                       input logic [63:0] a0, input logic [63:0] b0, input logic [1:0] op0,
                       input logic [63:0] a1, input logic [63:0] b1, input logic [1:0] op1,
                       input int stall, input bit scramble);
    int          g;
    int          n;
    bit          got;
    logic [63:0] exp;
    logic [63:0] mask;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    bus.res_ready  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("grant_timeout", 64'd0, 64'd1);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    g = ref_grant(v0, v1);
    chk("grant", {62'd0, bus.req1_ready, bus.req0_ready}, (g == 1) ? 64'd2 : 64'd1);
    grant_hist.push_back(g);
    exp = (g == 1) ? ref_result(a1, b1, op1) : ref_result(a0, b0, op0);
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= int'(NCHUNK) + 4; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (bus.res_valid) break;
      mask = (i * int'(CHUNK) >= int'(WIDTH)) ? '1 : ((64'd1 << (i * CHUNK)) - 64'd1);
      chk("partial_data", bus.res_data, exp & mask);
      chk("run_busy_noready", {61'd0, bus.busy, bus.req1_ready, bus.req0_ready}, 64'd4);
      if (scramble) begin
        bus.req0_a = rnd64(); bus.req0_b = rnd64(); bus.req0_op = 2'($urandom);
        bus.req1_a = rnd64(); bus.req1_b = rnd64(); bus.req1_op = 2'($urandom);
      end
    end
    chk("latency", 64'(n), 64'(NCHUNK + 1));
    if (!bus.res_valid) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    chk("res_data", bus.res_data, exp);
    chk("res_id", 64'(bus.res_id), 64'(g));
    chk("res_zero", 64'(bus.res_zero), 64'(exp == 64'd0));
    last_data = bus.res_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.res_valid), 64'd1);
      chk("stall_data", bus.res_data, exp);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    chk("no_grant_at_res_hs", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    chk("hs_data", bus.res_data, exp);
    @(posedge clk);
    #1;
    chk("post_hs_idle", {62'd0, bus.busy, bus.res_valid}, 64'd0);
    bus.res_ready = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ca;
    logic [63:0] cb;
    int          v;
    ca = 64'hFFFF0000FFFF0000;
    cb = 64'h0F0F0F0F0F0F0F0F;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00;
    bus.res_ready  = 1'b0;
    #1;
    chk("reset_outputs", {58'd0, bus.busy, bus.res_valid, bus.res_id, bus.res_zero,
                          bus.req1_ready, bus.req0_ready}, 64'd0);
    chk("reset_data", bus.res_data, 64'd0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single AND on req0, accepted in the first cycle after reset release.
    do_op(1, 0, ca, cb, 2'b00, 64'd0, 64'd0, 2'b00, 0, 0);
    chk("and_const", last_data, 64'h0F0F00000F0F0000);
    do_op(0, 1, 64'd0, 64'd0, 2'b00, ca, cb, 2'b01, 0, 0);
    chk("or_const", last_data, 64'hFFFF0F0FFFFF0F0F);
    do_op(0, 1, 64'd0, 64'd0, 2'b00, ca, cb, 2'b10, 0, 0);
    chk("xor_const", last_data, 64'hF0F00F0FF0F00F0F);
    do_op(0, 1, 64'd0, 64'd0, 2'b00, ca, cb, 2'b11, 0, 0);
    chk("zero_const", last_data, 64'd0);

    // Contention: both requesters valid, grants alternate.
    repeat (4) do_op(1, 1, rnd64(), rnd64(), 2'($urandom), rnd64(), rnd64(), 2'($urandom), 0, 0);

    // Backpressure, then operand scrambling during RUN.
    do_op(1, 0, rnd64(), rnd64(), 2'b10, 64'd0, 64'd0, 2'b00, 5, 0);
    do_op(1, 0, rnd64(), rnd64(), 2'b01, rnd64(), rnd64(), 2'b00, 0, 1);

    // Asynchronous reset at chunk 4 aborts the operation.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = rnd64(); bus.req0_b = rnd64(); bus.req0_op = 2'b01;
    bus.req1_valid = 1'b0;
    #1;
    chk("abort_grant", 64'(bus.req0_ready), 64'd1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {59'd0, bus.busy, bus.res_valid, bus.res_zero,
                          bus.req1_ready, bus.req0_ready}, 64'd0);
    chk("abort_data", bus.res_data, 64'd0);
    grant_hist.delete();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("no_stale_valid", {62'd0, bus.busy, bus.res_valid}, 64'd0);
    end
    do_op(1, 1, rnd64(), rnd64(), 2'b00, rnd64(), rnd64(), 2'b10, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      v = int'($urandom_range(1, 3));
      do_op(v[0], v[1], rnd64(), rnd64(), 2'($urandom), rnd64(), rnd64(), 2'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits.
REQ-002 Parameter: CHUNK, 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-006 Port: req0_ready / req1_ready  output  1 each  requester's operation accepted this cycle.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
REQ-008 Port: req0_op / req1_op  input  2 each  00 = AND, 01 = OR, 10 = XOR, 11 = constant 0.
REQ-009 Port: res_valid  output  1  result is held for the consumer.
REQ-010 Port: res_ready  input  1  consumer accepts the result.
REQ-011 Port: res_id  output  1  index of the requester that owns the result.
REQ-012 Port: res_data  output  WIDTH  bitwise result.
REQ-013 Port: res_zero  output  1  high when res_data == 0.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE, no valid request: the block SHALL stay in IDLE with both ready outputs low.
REQ-017 IDLE, exactly one valid request: the block SHALL assert that requester's ready combinationally in the same cycle.
REQ-018 IDLE, both valid: grant SHALL go to the requester not granted most recently (round-robin); after reset, req0 wins.
REQ-019 At most one ready SHALL be high in any cycle, and neither SHALL be high outside IDLE.
REQ-020 On a handshake (valid & ready), the block SHALL capture a, b, op and the requester id, clear the chunk counter, update the round-robin pointer, and go to RUN.
REQ-021 RUN: each cycle, chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) SHALL be computed per op by one shared CHUNK-bit gate slice and written to the result register; k then increments.
REQ-022 After the chunk with k = NCHUNK-1 is written, the next state SHALL be DONE; chunk processing order is k = 0 upward, with no skipping.
REQ-023 res_valid SHALL rise exactly NCHUNK+1 rising edges after the handshake edge (9 edges for the defaults).
REQ-024 DONE: res_valid, res_id, res_data and res_zero SHALL be held stable until res_valid & res_ready.
REQ-025 On the result handshake, the next state SHALL be IDLE; a new request SHALL NOT be accepted in the same cycle as the result handshake.
REQ-026 res_data bits not yet written in RUN SHALL read 0; res_valid SHALL be 0 outside DONE.
REQ-027 Requester inputs SHALL be ignored outside IDLE; changes to them during RUN or DONE SHALL NOT affect the result.
REQ-028 op = 11 SHALL produce an all-zero result with res_zero = 1, with the same latency as any other op.

Reset
REQ-029 While reset is high, regardless of clk, the block SHALL force:
- state = IDLE;
- res_valid, res_id, res_data, res_zero, busy and both ready outputs = 0;
- chunk counter = 0;
- round-robin pointer so that req0 has priority.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation; no res_valid SHALL appear for it after reset is released.
REQ-031 In the first cycle after reset is released, a valid request SHALL be accepted normally.

Verification
REQ-032 Single op, AND:
- Stimulus: req0 only, a = 0xFFFF0000FFFF0000, b = 0x0F0F0F0F0F0F0F0F, op = 00, res_ready = 1.
- Response: req0_ready high for one cycle; res_valid 9 edges later; res_data = 0x0F0F00000F0F0000; res_id = 0; res_zero = 0.
REQ-033 Other ops on the same operands, via req1:
- op = 01 -> res_data = 0xFFFF0F0FFFFF0F0F.
- op = 10 -> res_data = 0xF0F00F0FF0F00F0F.
- op = 11 -> res_data = 0 and res_zero = 1.
- All with res_id = 1.
REQ-034 Contention:
- Stimulus: both requesters valid continuously after reset.
- Response: grants alternate req0, req1, req0, req1; res_id sequence is 0, 1, 0, 1; neither ready is ever high during busy.
REQ-035 Backpressure:
- Stimulus: res_ready held low for 5 cycles in DONE.
- Response: res_valid and res_data stay stable for those cycles; when res_ready rises, one handshake occurs and the state returns to IDLE.
- The next request is accepted no earlier than the following cycle.
REQ-036 Reset mid-RUN:
- Stimulus: reset asserted at chunk 4 and asynchronously, away from a clk edge.
- Response: outputs go to 0 immediately; no res_valid afterwards; the next request (with req1 also valid) is granted to req0.
REQ-037 Operand change during RUN:
- Stimulus: req0_a and req0_b changed every cycle during RUN.
- Response: res_data matches the values captured at the handshake.
